// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, XOR-checksummed
// byte stream, assembles big-endian 16-bit words, writes them from address 0
// upward and releases the processor reset only after a good checksum.
module imem_loader #(
  parameter int ADDR_W     = 10,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  // Length is compared in 17 bits so a 16-bit count never truncates the depth.
  localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;       // one extra bit so N == IMEM_DEPTH fits
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic              accept;
  logic [ADDR_W:0]   cnt_inc;
  logic [15:0]       len_full;

  assign accept   = in_valid && ready_q;
  assign cnt_inc  = cnt_q + 1'b1;
  assign len_full = {len_q[15:8], in_data};

  // Next-state logic: advance the stream parser on each accepted byte.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (accept) begin
      if (state_q != S_CSUM) csum_d = csum_q ^ in_data;
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = in_data;
          if ({1'b0, len_full} > DEPTH_L) state_d = S_ERR;
          else if (len_full == 16'd0)     state_d = S_CSUM;
          else                            state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = {hi_q, in_data};
          cnt_d   = cnt_inc;
          if (17'(cnt_inc) < {1'b0, len_q}) state_d = S_DATA_HI;
          else                              state_d = S_CSUM;
        end
        S_CSUM: begin
          if (in_data == csum_q) state_d = S_DONE;
          else                   state_d = S_ERR;
        end
        default: ;
      endcase
    end

    // Status outputs follow the state being entered, so they change on the
    // same edge as the transition.
    ready_d     = (state_d != S_DONE) && (state_d != S_ERR);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_LEN_HI;
      cnt_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers push expected memory writes, a
// monitor pops and compares them whenever imem_we is seen.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  imem_loader #(.ADDR_W(ADDR_W), .IMEM_DEPTH(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each write strobe against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      check("done_and_error_exclusive", 32'(done && error), 32'd0);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", 32'(imem_wdata), 32'(e.data));
        end
      end
    end
  end

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Present one byte and hold it until accepted (bounded), then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    repeat (gap) begin
      @(posedge clk); #1;
      in_data = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_nominal(input logic [7:0] csum, input int gap);
    logic [7:0] bytes [7];
    bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, csum};
    for (int i = 0; i < 7; i++) send_byte(bytes[i], gap);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({tag, "_rst_in_ready"},  32'(in_ready),   32'd0);
    check({tag, "_rst_we"},        32'(imem_we),    32'd0);
    check({tag, "_rst_addr"},      32'(imem_addr),  32'd0);
    check({tag, "_rst_wdata"},     32'(imem_wdata), 32'd0);
    check({tag, "_rst_cpu_reset"}, 32'(cpu_reset),  32'd1);
    check({tag, "_rst_done"},      32'(done),       32'd0);
    check({tag, "_rst_error"},     32'(error),      32'd0);
    reset = 1'b0;
  endtask

  task automatic final_status(input string tag, input logic exp_done, input logic exp_err);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check({tag, "_done"},      32'(done),         32'(exp_done));
    check({tag, "_error"},     32'(error),        32'(exp_err));
    check({tag, "_cpu_reset"}, 32'(cpu_reset),    32'(!exp_done));
    check({tag, "_in_ready"},  32'(in_ready),     32'd0);
    check({tag, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Nominal load, checked tightly at the accepting edge of the checksum byte.
    do_reset("nom");
    expect_write(10'd0, 16'h1234);
    expect_write(10'd1, 16'hABCD);
    send_nominal(8'h42, 0);
    check("nom_cpu_reset_edge", 32'(cpu_reset), 32'd0);
    check("nom_done_edge",      32'(done),      32'd1);
    // Input after completion must be ignored (monitor flags any write).
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (5) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    final_status("nom", 1'b1, 1'b0);

    // Empty image.
    do_reset("empty");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    final_status("empty", 1'b1, 1'b0);

    // Oversize length 1025.
    do_reset("over");
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("over_error_edge",    32'(error),     32'd1);
    check("over_in_ready_edge", 32'(in_ready),  32'd0);
    check("over_cpu_reset",     32'(cpu_reset), 32'd1);
    final_status("over", 1'b0, 1'b1);

    // Boundary: N == IMEM_DEPTH (04 00) is legal and goes to data.
    do_reset("edge");
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    check("edge_len_error", 32'(error),    32'd0);
    check("edge_len_ready", 32'(in_ready), 32'd1);

    // Checksum mismatch.
    do_reset("bad");
    expect_write(10'd0, 16'h1234);
    expect_write(10'd1, 16'hABCD);
    send_nominal(8'h43, 0);
    final_status("bad", 1'b0, 1'b1);

    // Backpressure: three idle cycles between bytes.
    do_reset("bp");
    expect_write(10'd0, 16'h1234);
    expect_write(10'd1, 16'hABCD);
    send_nominal(8'h42, 3);
    final_status("bp", 1'b1, 1'b0);

    // Reset after first data word, then full reload from address 0.
    do_reset("mid");
    expect_write(10'd0, 16'h1234);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 2);
    check("mid_first_word", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_cpu_reset_in_rst", 32'(cpu_reset), 32'd1);
    check("mid_ready_in_rst",     32'(in_ready),  32'd0);
    reset = 1'b0;
    expect_write(10'd0, 16'h1234);
    expect_write(10'd1, 16'hABCD);
    send_nominal(8'h42, 0);
    final_status("mid", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
